bias_add_relu_4: RTL
====================

BIAS_ADD_RELU_4 -- requirements
Module: bias_add_relu_4

Interface
REQ-001 SHALL have parameter COEFF_WIDTH, default 16: bias word width, signed.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: accumulator word width, signed.
REQ-003 SHALL have parameter OUT_WIDTH, default 16: output activation width, signed.
REQ-004 SHALL have parameter NUM_CH, default 16: output channels per pixel, equal to the bias count.
REQ-005 SHALL have parameter NUM_PIX, default 64: pixels per frame.
REQ-006 SHALL have parameter BIAS_SHIFT, default 8: left shift aligning bias to the accumulator fixed point.
REQ-007 SHALL have parameter FRAC_SHIFT, default 8: arithmetic right shift from accumulator to output fixed point.
REQ-008 SHALL have one clock, ap_clk; reset ap_rst is synchronous and active-high.
REQ-009 SHALL have port ap_clk, input, 1 bit: clock, rising edge.
REQ-010 SHALL have port ap_rst, input, 1 bit: synchronous active-high reset.
REQ-011 SHALL have port bias_V_dout, input, COEFF_WIDTH bits: bias stream data.
REQ-012 SHALL have port bias_V_empty_n, input, 1 bit: bias stream has data.
REQ-013 SHALL have port bias_V_read, output, 1 bit: pop bias stream.
REQ-014 SHALL have port input_V_dout, input, ACC_WIDTH bits: accumulator stream data, channel-interleaved.
REQ-015 SHALL have port input_V_empty_n, input, 1 bit: accumulator stream has data.
REQ-016 SHALL have port input_V_read, output, 1 bit: pop accumulator stream.
REQ-017 SHALL have port output_V_din, output, OUT_WIDTH bits: activation data.
REQ-018 SHALL have port output_V_full_n, input, 1 bit: downstream can accept.
REQ-019 SHALL have port output_V_write, output, 1 bit: push activation.
REQ-020 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last activation of a frame is written.

Function
REQ-021 SHALL implement states LOAD and RUN; after reset the state SHALL be LOAD.
REQ-022 In LOAD: bias_V_read = bias_V_empty_n; each popped word SHALL be stored at bias_reg[ch_cnt]; ch_cnt increments; after the NUM_CH-th pop, ch_cnt -> 0 and the state -> RUN.
REQ-023 In RUN: input_V_read = input_V_empty_n AND (NOT out_valid OR output_V_full_n); bias_V_read SHALL be 0.
REQ-024 Per accumulator pop: sum = input_V_dout + (sign-extended bias_reg[ch_cnt] << BIAS_SHIFT), computed at ACC_WIDTH+1 bits without wrap.
REQ-025 res = sum >>> FRAC_SHIFT (arithmetic); res < 0 -> 0 (ReLU); res > 2^(OUT_WIDTH-1)-1 -> 2^(OUT_WIDTH-1)-1 (saturate).
REQ-026 res SHALL be registered into output_V_din with out_valid set on the cycle after the pop; latency is 1 cycle.
REQ-027 output_V_write = out_valid AND output_V_full_n; out_valid clears on write unless a new pop occurs in the same cycle; a simultaneous write and pop SHALL sustain 1 word/cycle.
REQ-028 While output_V_full_n = 0, output_V_din and out_valid SHALL hold and no accumulator pop SHALL occur.
REQ-029 ch_cnt SHALL wrap NUM_CH-1 -> 0 and then increment pix_cnt; on the pop with ch_cnt = NUM_CH-1 and pix_cnt = NUM_PIX-1, both counters -> 0 and the state -> LOAD.
REQ-030 Bias loading of the next frame MAY overlap the draining of the final output word.
REQ-031 frame_done SHALL pulse for one cycle in the cycle after the write of the frame's last output word.

Reset
REQ-032 On ap_rst = 1 at a rising edge: state = LOAD, ch_cnt = pix_cnt = 0, out_valid = 0, output_V_din = 0, frame_done = 0; bias_V_read, input_V_read and output_V_write SHALL be 0 while ap_rst = 1.
REQ-033 Reset mid-RUN SHALL discard partial-frame state; the next frame SHALL start with a fresh LOAD of NUM_CH biases.
REQ-034 bias_reg contents need not be reset.

Verification (NUM_CH=2, NUM_PIX=2, defaults otherwise)
REQ-035 Basic: biases {16, -4}; accumulators {256, 1280, 512, 1536}; full_n = 1 -> outputs {17, 1, 18, 2}, one per cycle, then one frame_done pulse.
REQ-036 ReLU/saturation: bias 16, accumulator -8192 -> output 0; accumulator 0x7FFFFF00 -> output 32767.
REQ-037 Backpressure: hold full_n = 0 for 5 cycles mid-frame -> output_V_din stable, input_V_read = 0, no data lost or duplicated.
REQ-038 Sparse input: toggle input_V_empty_n randomly -> same output sequence as the basic case, correct channel/bias pairing.
REQ-039 Reset after 3 pops in RUN -> all outputs 0 next cycle; a fresh frame processed correctly after reset.
REQ-040 Back-to-back: two frames with different bias sets -> second frame uses new biases; no accumulator pop during LOAD.

Source files
------------

// File: rtl/bias_add_relu_4.sv
// Bias-add + ReLU/saturate stage: loads NUM_CH biases per frame, then streams
// NUM_CH*NUM_PIX channel-interleaved accumulators through a 1-cycle output register.
module bias_add_relu_4 #(
   parameter int COEFF_WIDTH = 16,
   parameter int ACC_WIDTH   = 32,
   parameter int OUT_WIDTH   = 16,
   parameter int NUM_CH      = 16,
   parameter int NUM_PIX     = 64,
   parameter int BIAS_SHIFT  = 8,
   parameter int FRAC_SHIFT  = 8
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst,
   input  logic signed [COEFF_WIDTH-1:0] bias_V_dout,
   input  logic                        bias_V_empty_n,
   output logic                        bias_V_read,
   input  logic signed [ACC_WIDTH-1:0] input_V_dout,
   input  logic                        input_V_empty_n,
   output logic                        input_V_read,
   output logic signed [OUT_WIDTH-1:0] output_V_din,
   input  logic                        output_V_full_n,
   output logic                        output_V_write,
   output logic                        frame_done
);

   localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
   localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
   localparam logic signed [ACC_WIDTH:0] OUT_MAX =
      {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};

   typedef enum logic {LOAD, RUN} state_t;

   state_t                      state;
   logic [CH_W-1:0]             ch_cnt;
   logic [PIX_W-1:0]            pix_cnt;
   logic                        out_valid;
   logic                        out_last;
   logic signed [COEFF_WIDTH-1:0] bias_reg [NUM_CH];

   logic signed [COEFF_WIDTH-1:0] bias_sel;
   logic signed [ACC_WIDTH:0]   acc_ext;
   logic signed [ACC_WIDTH:0]   bias_ext;
   logic signed [ACC_WIDTH:0]   sum_p0;
   logic                        ch_last;
   logic                        pix_last;
   logic                        run_pop;

   // Shift down to the output fixed point, then clamp into [0, OUT_MAX].
   function automatic logic signed [OUT_WIDTH-1:0] relu_sat(input logic signed [ACC_WIDTH:0] s);
      logic signed [ACC_WIDTH:0] shifted;
      shifted = s >>> FRAC_SHIFT;
      if (shifted[ACC_WIDTH])
         return '0;
      else if (shifted > OUT_MAX)
         return OUT_MAX[OUT_WIDTH-1:0];
      else
         return shifted[OUT_WIDTH-1:0];
   endfunction

   assign ch_last  = (ch_cnt  == CH_W'(NUM_CH - 1));
   assign pix_last = (pix_cnt == PIX_W'(NUM_PIX - 1));

   assign bias_V_read    = !ap_rst && (state == LOAD) && bias_V_empty_n;
   assign run_pop        = !ap_rst && (state == RUN) && input_V_empty_n
                           && (!out_valid || output_V_full_n);
   assign input_V_read   = run_pop;
   assign output_V_write = !ap_rst && out_valid && output_V_full_n;

   // Stage p0: bias alignment and one-bit-wider sum so the add can never wrap.
   always_comb begin
      bias_sel = bias_reg[ch_cnt];
      acc_ext  = {input_V_dout[ACC_WIDTH-1], input_V_dout};
      bias_ext = {{(ACC_WIDTH + 1 - COEFF_WIDTH){bias_sel[COEFF_WIDTH-1]}}, bias_sel};
      sum_p0   = acc_ext + (bias_ext <<< BIAS_SHIFT);
   end

   always_ff @(posedge ap_clk) begin
      if (bias_V_read)
         bias_reg[ch_cnt] <= bias_V_dout;
   end

   // Stage p1: registered activation, control counters and frame sequencing.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state        <= LOAD;
         ch_cnt       <= '0;
         pix_cnt      <= '0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         output_V_din <= '0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= output_V_write && out_last;

         if (run_pop) begin
            output_V_din <= relu_sat(sum_p0);
            out_valid    <= 1'b1;
            out_last     <= ch_last && pix_last;
         end else if (output_V_write) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         case (state)
            LOAD: begin
               if (bias_V_read) begin
                  if (ch_last) begin
                     ch_cnt <= '0;
                     state  <= RUN;
                  end else begin
                     ch_cnt <= ch_cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               if (run_pop) begin
                  if (ch_last) begin
                     ch_cnt <= '0;
                     if (pix_last) begin
                        pix_cnt <= '0;
                        state   <= LOAD;
                     end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                     end
                  end else begin
                     ch_cnt <= ch_cnt + 1'b1;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule
